vx_mem_req_rr_arb: RTL

Round-robin arbiter that shares one memory request port among `NUM_REQS` requesters (cache banks, DMA, or core memory ports). It sits between several requester-side memory request channels and a single downstream memory request channel, using the same valid/ready/rw/byteen/addr/data/tag bundle. The requester index is appended to the tag so that the response path can route replies back. A one-entry output register decouples the arbitration logic from downstream `ready`.

---
 rtl/vx_mem_req_rr_arb.sv | 113 +++++++++++
 1 files changed

// File: rtl/vx_mem_req_rr_arb.sv
// Round-robin arbiter merging NUM_REQS memory request channels into one registered output channel.
// Optional counters enabled by defining VX_MEM_ARB_PERF_EN.
module vx_mem_req_rr_arb #(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned DATA_SIZE  = DATA_WIDTH / 8,
  localparam int unsigned SEL_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid,
  input  logic [NUM_REQS-1:0]              req_rw,
  input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag,
  output logic [NUM_REQS-1:0]              req_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [DATA_SIZE-1:0]             mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_WIDTH+SEL_BITS-1:0]    mem_req_tag,
  input  logic                             mem_req_ready
`ifdef VX_MEM_ARB_PERF_EN
  ,
  output logic [31:0]                      perf_stalls,
  output logic [NUM_REQS*32-1:0]           perf_grants
`endif
);

  localparam int unsigned IDX_W = SEL_BITS + 1;

  logic [SEL_BITS-1:0] ptr;
  logic [SEL_BITS-1:0] winner_c;
  logic [SEL_BITS-1:0] sel_c;
  logic [SEL_BITS-1:0] ptr_next_c;
  logic [IDX_W-1:0]    idx_c;
  logic                found_c;
  logic                can_load_c;
  logic                accept_c;

  // Circular search for the first valid requester starting at ptr.
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    idx_c    = '0;
    sel_c    = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      idx_c = {1'b0, ptr} + IDX_W'(i);
      if (idx_c >= IDX_W'(NUM_REQS)) begin
        idx_c = idx_c - IDX_W'(NUM_REQS);
      end
      sel_c = SEL_BITS'(idx_c);
      if (!found_c && req_valid[sel_c]) begin
        winner_c = sel_c;
        found_c  = 1'b1;
      end
    end
  end

  always_comb begin
    can_load_c = !mem_req_valid || mem_req_ready;
    accept_c   = found_c && can_load_c && reset;
    req_ready  = accept_c ? (NUM_REQS'(1) << winner_c) : '0;
    ptr_next_c = (winner_c == SEL_BITS'(NUM_REQS - 1)) ? '0 : winner_c + SEL_BITS'(1);
  end

  // Output register: loads on accept, drains when downstream takes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr            <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_byteen <= '0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      mem_req_tag    <= '0;
    end else if (accept_c) begin
      ptr            <= ptr_next_c;
      mem_req_valid  <= 1'b1;
      mem_req_rw     <= req_rw[winner_c];
      mem_req_byteen <= req_byteen[winner_c*DATA_SIZE +: DATA_SIZE];
      mem_req_addr   <= req_addr[winner_c*ADDR_WIDTH +: ADDR_WIDTH];
      mem_req_data   <= req_data[winner_c*DATA_WIDTH +: DATA_WIDTH];
      mem_req_tag    <= {req_tag[winner_c*TAG_WIDTH +: TAG_WIDTH], winner_c};
    end else if (mem_req_ready) begin
      mem_req_valid  <= 1'b0;
    end
  end

`ifdef VX_MEM_ARB_PERF_EN
  // Stall and per-requester grant counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stalls <= '0;
      perf_grants <= '0;
    end else begin
      if (|req_valid && !can_load_c) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        if (accept_c && (winner_c == SEL_BITS'(i))) begin
          perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule
